cmd_assembler: RTL and testbench

CMD_ASSEMBLER -- requirements
Module: cmd_assembler

---
 rtl/cmd_assembler.sv | 152 +++++++++++++++
 tb/tb_cmd_assembler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cmd_assembler.sv
// cmd_assembler: builds 3-byte command frames {cmd, data_hi, data_lo} from a
// UART byte stream, with an inter-byte timeout that discards partial frames.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_rdy       byte available from UART receiver (held until cleared)
//   rx_data[7:0] received byte, valid while rx_rdy is high
//   clr_cmd_rdy  consumer acknowledge, clears cmd_rdy
//   clr_rx_rdy   combinational acknowledge to the receiver (capture cycle)
//   cmd[7:0]     command byte of the last completed frame
//   data[15:0]   payload of the last completed frame {hi, lo}
//   cmd_rdy      completed frame available
//   frm_err      one-cycle pulse: partial frame dropped on timeout
//   ovr          one-cycle pulse: frame completed while cmd_rdy still set
module cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        clr_cmd_rdy,
  output logic        clr_rx_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        frm_err,
  output logic        ovr
);

  // Counter is at least 17 bits wide and large enough for any TIMEOUT_CYC.
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYC) > 17) ? $clog2(TIMEOUT_CYC) : 17;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_HI  = 2'd1,
    WAIT_LO  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_stg_q, cmd_stg_d;
  logic [7:0]       hi_stg_q, hi_stg_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [15:0]      data_q, data_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             frm_err_q, frm_err_d;
  logic             ovr_q, ovr_d;
  logic             timeout;

  // Every cycle with rx_rdy high is a capture cycle; nothing is acked in reset.
  assign clr_rx_rdy = rx_rdy & rst_n;

  // Timeout fires only mid-frame and only when no byte arrives this cycle.
  assign timeout = (state_q != WAIT_CMD) && !rx_rdy && (cnt_q == CNT_LAST);

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_stg_d = cmd_stg_q;
    hi_stg_d  = hi_stg_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    cmd_rdy_d = cmd_rdy_q;
    frm_err_d = 1'b0;
    ovr_d     = 1'b0;

    if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end

    case (state_q)
      WAIT_CMD: begin
        cnt_d = '0;
        if (rx_rdy) begin
          cmd_stg_d = rx_data;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_stg_d = rx_data;
          cnt_d    = '0;
          state_d  = WAIT_LO;
        end else if (!timeout) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d     = cmd_stg_q;
          data_d    = {hi_stg_q, rx_data};
          // Set wins over a same-cycle clear; overrun only if nobody consumed.
          cmd_rdy_d = 1'b1;
          ovr_d     = cmd_rdy_q & ~clr_cmd_rdy;
          cnt_d     = '0;
          state_d   = WAIT_CMD;
        end else if (!timeout) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_CMD;
        cnt_d   = '0;
      end
    endcase

    // Drop the partial frame; output registers are untouched.
    if (timeout) begin
      state_d   = WAIT_CMD;
      cnt_d     = '0;
      cmd_stg_d = '0;
      hi_stg_d  = '0;
      frm_err_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_CMD;
      cnt_q     <= '0;
      cmd_stg_q <= '0;
      hi_stg_q  <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      cmd_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_stg_q <= cmd_stg_d;
      hi_stg_q  <= hi_stg_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      cmd_rdy_q <= cmd_rdy_d;
      frm_err_q <= frm_err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign cmd     = cmd_q;
  assign data    = data_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;
  assign ovr     = ovr_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Testbench for cmd_assembler: directed byte sequences with a frame scoreboard.
module tb_cmd_assembler;

  localparam int unsigned TO = 40;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_cmd_rdy;
  logic        clr_rx_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        frm_err;
  logic        ovr;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic        prev_rdy = 1'b0;

  cmd_assembler #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .data        (data),
    .cmd_rdy     (cmd_rdy),
    .frm_err     (frm_err),
    .ovr         (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one byte, hold rx_rdy until the capture edge, verify the 1-cycle ack.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1 chk("clr_rx_rdy_hi", 32'(clr_rx_rdy), 32'd1);
    @(posedge clk);
    #1 rx_rdy = 1'b0;
    #1 chk("clr_rx_rdy_lo", 32'(clr_rx_rdy), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
    send_byte(c);
    send_byte(h);
    exp_q.push_back({c, h, l});
    send_byte(l);
  endtask

  task automatic ack_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1 clr_cmd_rdy = 1'b0;
  endtask

  // Scoreboard: a new frame shows up as a cmd_rdy rise or an overrun pulse.
  always @(negedge clk) begin
    if (rst_n && cmd_rdy && (!prev_rdy || ovr)) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_frame", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("sb_cmd", 32'(cmd), 32'(e[23:16]));
        chk("sb_data", 32'(data), 32'(e[15:0]));
      end
    end
    prev_rdy = rst_n ? cmd_rdy : 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    rx_rdy      = 1'b0;
    rx_data     = 8'h00;
    clr_cmd_rdy = 1'b0;
    #12;
    chk("rst_cmd", 32'(cmd), 32'h00);
    chk("rst_data", 32'(data), 32'h0000);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_frm_err", 32'(frm_err), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rx_rdy = 1'b1;
    #1 chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    rx_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame.
    send_frame(8'h02, 8'hA5, 8'h5A);
    chk("f1_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("f1_cmd", 32'(cmd), 32'h02);
    chk("f1_data", 32'(data), 32'hA55A);
    chk("f1_ovr", 32'(ovr), 32'd0);

    // Consumer acknowledge.
    ack_cmd();
    chk("ack_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("ack_cmd_hold", 32'(cmd), 32'h02);
    chk("ack_data_hold", 32'(data), 32'hA55A);

    // Timeout after a lone cmd byte.
    send_byte(8'h05);
    repeat (TO - 1) @(posedge clk);
    #1 chk("to_frm_err_early", 32'(frm_err), 32'd0);
    @(posedge clk);
    #1 chk("to_frm_err_pulse", 32'(frm_err), 32'd1);
    chk("to_cmd_rdy_kept", 32'(cmd_rdy), 32'd0);
    chk("to_cmd_kept", 32'(cmd), 32'h02);
    chk("to_data_kept", 32'(data), 32'hA55A);
    @(posedge clk);
    #1 chk("to_frm_err_end", 32'(frm_err), 32'd0);
    send_frame(8'h06, 8'h00, 8'h10);
    chk("f2_cmd", 32'(cmd), 32'h06);
    chk("f2_data", 32'(data), 32'h0010);

    // Overrun: second frame without acknowledge.
    send_frame(8'h07, 8'h12, 8'h34);
    chk("ovr_pulse", 32'(ovr), 32'd1);
    chk("ovr_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("ovr_cmd", 32'(cmd), 32'h07);
    chk("ovr_data", 32'(data), 32'h1234);
    @(posedge clk);
    #1 chk("ovr_end", 32'(ovr), 32'd0);
    chk("ovr_cmd_rdy_hold", 32'(cmd_rdy), 32'd1);
    ack_cmd();

    // Low byte lands exactly on the last counter value: capture wins.
    send_byte(8'h0A);
    send_byte(8'h0B);
    exp_q.push_back({8'h0A, 8'h0B, 8'h0C});
    repeat (TO - 1) @(posedge clk);
    send_byte(8'h0C);
    chk("edge_frm_err", 32'(frm_err), 32'd0);
    chk("edge_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("edge_data", 32'(data), 32'h0B0C);
    @(posedge clk);
    #1 chk("edge_frm_err_next", 32'(frm_err), 32'd0);

    // Reset mid-frame discards partial bytes.
    send_byte(8'h08);
    send_byte(8'h99);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_cmd", 32'(cmd), 32'h00);
    chk("mrst_data", 32'(data), 32'h0000);
    chk("mrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("mrst_frm_err", 32'(frm_err), 32'd0);
    chk("mrst_ovr", 32'(ovr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h01, 8'h00, 8'h02);
    chk("post_rst_cmd", 32'(cmd), 32'h01);
    chk("post_rst_data", 32'(data), 32'h0002);
    chk("post_rst_cmd_rdy", 32'(cmd_rdy), 32'd1);

    repeat (3) @(posedge clk);
    #1 chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
